// File: rtl/nf_axis_port_stats_pkg.sv
// Shared helpers for the 10GE port statistics block: default widths,
// tkeep popcount and the counter add / overflow / wrap-or-saturate rule.
package nf_axis_port_stats_pkg;

  localparam int C_CNT_WIDTH_DEF = 32;
  localparam int C_LEN_WIDTH_DEF = 16;

  function automatic logic [7:0] popcount(input logic [127:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 128; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  // Bit [w-1] of cur is the sticky flag; the count field is bits [w-2:0].
  function automatic logic [63:0] cnt_update(input logic [63:0] cur,
                                             input logic [63:0] inc,
                                             input int          w,
                                             input bit          sat);
    logic [63:0] mask;
    logic [63:0] sum;
    logic        flag;
    logic        ovf;
    mask = (64'd1 << (w - 1)) - 64'd1;
    sum  = (cur & mask) + inc;
    flag = |(cur & (64'd1 << (w - 1)));
    ovf  = (sum > mask);
    if (ovf) sum = sat ? mask : (sum & mask);
    return sum | (64'(flag | ovf) << (w - 1));
  endfunction

endpackage

// File: rtl/nf_axis_stats_channel.sv
// One tapped direction: beat register stage, then packet/byte counters,
// in-packet length accumulator and longest-packet register.
module nf_axis_stats_channel
  import nf_axis_port_stats_pkg::*;
#(
  parameter int KW    = 32,
  parameter int CNT_W = C_CNT_WIDTH_DEF,
  parameter int LEN_W = C_LEN_WIDTH_DEF,
  parameter int SAT   = 0
) (
  input  logic             core_clk,
  input  logic             core_resetn,
  input  logic [KW-1:0]    tkeep,
  input  logic             tvalid,
  input  logic             tready,
  input  logic             tlast,
  input  logic             clear_all,
  input  logic             pkt_clear,
  input  logic             byte_clear,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [LEN_W-1:0] max_len
);

  localparam int NB_W = $clog2(KW) + 1;

  logic             beat_v;
  logic             last;
  logic [NB_W-1:0]  nbytes;
  logic [LEN_W-1:0] pkt_acc;
  logic [LEN_W:0]   acc_raw;
  logic [LEN_W-1:0] acc_sum;

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) begin
      beat_v <= 1'b0;
      last   <= 1'b0;
      nbytes <= '0;
    end else begin
      beat_v <= tvalid & tready;
      last   <= tlast;
      nbytes <= NB_W'(popcount(128'(tkeep)));
    end
  end

  // Running packet length including the beat now in stage 2, held at all-ones.
  always_comb begin
    acc_raw = {1'b0, pkt_acc} + (LEN_W + 1)'(nbytes);
    acc_sum = acc_raw[LEN_W] ? '1 : acc_raw[LEN_W-1:0];
  end

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) byte_cnt <= '0;
    else if (clear_all || byte_clear) byte_cnt <= '0;
    else if (beat_v)
      byte_cnt <= CNT_W'(cnt_update(64'(byte_cnt), 64'(nbytes), CNT_W, SAT != 0));
  end

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) pkt_cnt <= '0;
    else if (clear_all || pkt_clear) pkt_cnt <= '0;
    else if (beat_v && last)
      pkt_cnt <= CNT_W'(cnt_update(64'(pkt_cnt), 64'd1, CNT_W, SAT != 0));
  end

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) begin
      pkt_acc <= '0;
      max_len <= '0;
    end else if (clear_all) begin
      pkt_acc <= '0;
      max_len <= '0;
    end else if (beat_v) begin
      pkt_acc <= last ? '0 : acc_sum;
      if (last && (acc_sum > max_len)) max_len <= acc_sum;
    end
  end

endmodule

// File: rtl/nf_axis_port_stats.sv
// RX/TX traffic statistics for a 10GE port: two tap channels, the clear
// fan-out, optional snapshot shadow registers and the snapshot acknowledge.
module nf_axis_port_stats
  import nf_axis_port_stats_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_CNT_WIDTH       = C_CNT_WIDTH_DEF,
  parameter int C_SATURATE        = 0,
  parameter int C_SNAPSHOT        = 1,
  parameter int C_LEN_WIDTH       = C_LEN_WIDTH_DEF
) (
  input  logic                           core_clk,
  input  logic                           core_resetn,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] rx_tkeep,
  input  logic                           rx_tvalid,
  input  logic                           rx_tready,
  input  logic                           rx_tlast,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] tx_tkeep,
  input  logic                           tx_tvalid,
  input  logic                           tx_tready,
  input  logic                           tx_tlast,
  input  logic                           clear_counters,
  input  logic                           rx_pkt_clear,
  input  logic                           rx_byte_clear,
  input  logic                           tx_pkt_clear,
  input  logic                           tx_byte_clear,
  input  logic                           snapshot_req,
  output logic                           snapshot_ack,
  output logic [C_CNT_WIDTH-1:0]         rx_pkt_cnt,
  output logic [C_CNT_WIDTH-1:0]         rx_byte_cnt,
  output logic [C_CNT_WIDTH-1:0]         tx_pkt_cnt,
  output logic [C_CNT_WIDTH-1:0]         tx_byte_cnt,
  output logic [C_LEN_WIDTH-1:0]         rx_max_len,
  output logic [C_LEN_WIDTH-1:0]         tx_max_len
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;

  logic [C_CNT_WIDTH-1:0] rx_pkt_live, rx_byte_live, tx_pkt_live, tx_byte_live;

  nf_axis_stats_channel #(
    .KW(KW), .CNT_W(C_CNT_WIDTH), .LEN_W(C_LEN_WIDTH), .SAT(C_SATURATE)
  ) u_rx (
    .core_clk(core_clk), .core_resetn(core_resetn),
    .tkeep(rx_tkeep), .tvalid(rx_tvalid), .tready(rx_tready), .tlast(rx_tlast),
    .clear_all(clear_counters), .pkt_clear(rx_pkt_clear), .byte_clear(rx_byte_clear),
    .pkt_cnt(rx_pkt_live), .byte_cnt(rx_byte_live), .max_len(rx_max_len)
  );

  nf_axis_stats_channel #(
    .KW(KW), .CNT_W(C_CNT_WIDTH), .LEN_W(C_LEN_WIDTH), .SAT(C_SATURATE)
  ) u_tx (
    .core_clk(core_clk), .core_resetn(core_resetn),
    .tkeep(tx_tkeep), .tvalid(tx_tvalid), .tready(tx_tready), .tlast(tx_tlast),
    .clear_all(clear_counters), .pkt_clear(tx_pkt_clear), .byte_clear(tx_byte_clear),
    .pkt_cnt(tx_pkt_live), .byte_cnt(tx_byte_live), .max_len(tx_max_len)
  );

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) snapshot_ack <= 1'b0;
    else              snapshot_ack <= snapshot_req;
  end

  // Shadows load the pre-edge live values, so a same-cycle clear reads atomically.
  if (C_SNAPSHOT != 0) begin : g_shadow
    logic [C_CNT_WIDTH-1:0] rx_pkt_sh, rx_byte_sh, tx_pkt_sh, tx_byte_sh;

    always_ff @(posedge core_clk or negedge core_resetn) begin
      if (!core_resetn) begin
        rx_pkt_sh  <= '0;
        rx_byte_sh <= '0;
        tx_pkt_sh  <= '0;
        tx_byte_sh <= '0;
      end else if (snapshot_req) begin
        rx_pkt_sh  <= rx_pkt_live;
        rx_byte_sh <= rx_byte_live;
        tx_pkt_sh  <= tx_pkt_live;
        tx_byte_sh <= tx_byte_live;
      end
    end

    assign rx_pkt_cnt  = rx_pkt_sh;
    assign rx_byte_cnt = rx_byte_sh;
    assign tx_pkt_cnt  = tx_pkt_sh;
    assign tx_byte_cnt = tx_byte_sh;
  end else begin : g_live
    assign rx_pkt_cnt  = rx_pkt_live;
    assign rx_byte_cnt = rx_byte_live;
    assign tx_pkt_cnt  = tx_pkt_live;
    assign tx_byte_cnt = tx_byte_live;
  end

endmodule

// File: tb/tb_nf_axis_port_stats.sv
// Bench for nf_axis_port_stats: a 32-bit snapshot instance plus two 8-bit live
// instances (wrap and saturate) share one stimulus and one totals-based model.
module tb_nf_axis_port_stats;

  localparam int KW = 32;

  logic core_clk = 1'b0;
  logic core_resetn;
  always #5 core_clk = ~core_clk;

  logic [KW-1:0] rx_tkeep, tx_tkeep;
  logic rx_tvalid, rx_tready, rx_tlast, tx_tvalid, tx_tready, tx_tlast;
  logic clear_counters, rx_pkt_clear, rx_byte_clear, tx_pkt_clear, tx_byte_clear;
  logic snapshot_req;

  logic        snapshot_ack;
  logic [31:0] rx_pkt_cnt, rx_byte_cnt, tx_pkt_cnt, tx_byte_cnt;
  logic [15:0] rx_max_len, tx_max_len;
  logic        w_ack, s_ack;
  logic [7:0]  w_rx_pkt, w_rx_byte, w_tx_pkt, w_tx_byte;
  logic [7:0]  s_rx_pkt, s_rx_byte, s_tx_pkt, s_tx_byte;
  logic [15:0] w_rx_max, w_tx_max, s_rx_max, s_tx_max;

  nf_axis_port_stats dut (
    .core_clk(core_clk), .core_resetn(core_resetn),
    .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .clear_counters(clear_counters), .rx_pkt_clear(rx_pkt_clear), .rx_byte_clear(rx_byte_clear),
    .tx_pkt_clear(tx_pkt_clear), .tx_byte_clear(tx_byte_clear),
    .snapshot_req(snapshot_req), .snapshot_ack(snapshot_ack),
    .rx_pkt_cnt(rx_pkt_cnt), .rx_byte_cnt(rx_byte_cnt), .tx_pkt_cnt(tx_pkt_cnt),
    .tx_byte_cnt(tx_byte_cnt), .rx_max_len(rx_max_len), .tx_max_len(tx_max_len)
  );

  nf_axis_port_stats #(.C_CNT_WIDTH(8), .C_SATURATE(0), .C_SNAPSHOT(0)) dut_w (
    .core_clk(core_clk), .core_resetn(core_resetn),
    .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .clear_counters(clear_counters), .rx_pkt_clear(rx_pkt_clear), .rx_byte_clear(rx_byte_clear),
    .tx_pkt_clear(tx_pkt_clear), .tx_byte_clear(tx_byte_clear),
    .snapshot_req(snapshot_req), .snapshot_ack(w_ack),
    .rx_pkt_cnt(w_rx_pkt), .rx_byte_cnt(w_rx_byte), .tx_pkt_cnt(w_tx_pkt),
    .tx_byte_cnt(w_tx_byte), .rx_max_len(w_rx_max), .tx_max_len(w_tx_max)
  );

  nf_axis_port_stats #(.C_CNT_WIDTH(8), .C_SATURATE(1), .C_SNAPSHOT(0)) dut_s (
    .core_clk(core_clk), .core_resetn(core_resetn),
    .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .clear_counters(clear_counters), .rx_pkt_clear(rx_pkt_clear), .rx_byte_clear(rx_byte_clear),
    .tx_pkt_clear(tx_pkt_clear), .tx_byte_clear(tx_byte_clear),
    .snapshot_req(snapshot_req), .snapshot_ack(s_ack),
    .rx_pkt_cnt(s_rx_pkt), .rx_byte_cnt(s_rx_byte), .tx_pkt_cnt(s_tx_pkt),
    .tx_byte_cnt(s_tx_byte), .rx_max_len(s_rx_max), .tx_max_len(s_tx_max)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: true totals since the last clear; register format derived on demand.
  longint unsigned m_pkt[2], m_byte[2], m_acc[2], m_max[2], s_pkt[2], s_byte[2];
  bit              p_v[2], p_last[2];
  int              p_bytes[2];
  bit              m_ack;

  function automatic logic [63:0] fmt(input longint unsigned t, input int w, input bit sat);
    longint unsigned m;
    m = (64'd1 << (w - 1)) - 64'd1;
    if (t <= m) return 64'(t);
    return (64'd1 << (w - 1)) | (sat ? 64'(m) : 64'(t % (m + 1)));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pkt[d] = 0; m_byte[d] = 0; m_acc[d] = 0; m_max[d] = 0;
      s_pkt[d] = 0; s_byte[d] = 0; p_v[d] = 0; p_last[d] = 0; p_bytes[d] = 0;
    end
    m_ack = 0;
  endtask

  task automatic model_step();
    bit pclr[2], bclr[2];
    longint unsigned s;
    pclr[0] = rx_pkt_clear;  pclr[1] = tx_pkt_clear;
    bclr[0] = rx_byte_clear; bclr[1] = tx_byte_clear;
    m_ack = snapshot_req;
    for (int d = 0; d < 2; d++) begin
      if (snapshot_req) begin s_pkt[d] = m_pkt[d]; s_byte[d] = m_byte[d]; end
      if (clear_counters || bclr[d]) m_byte[d] = 0;
      else if (p_v[d]) m_byte[d] += p_bytes[d];
      if (clear_counters || pclr[d]) m_pkt[d] = 0;
      else if (p_v[d] && p_last[d]) m_pkt[d] += 1;
      if (clear_counters) begin
        m_acc[d] = 0; m_max[d] = 0;
      end else if (p_v[d]) begin
        s = m_acc[d] + p_bytes[d];
        if (s > 65535) s = 65535;
        if (p_last[d]) begin
          if (s > m_max[d]) m_max[d] = s;
          m_acc[d] = 0;
        end else m_acc[d] = s;
      end
    end
    p_v[0] = rx_tvalid && rx_tready; p_bytes[0] = $countones(rx_tkeep); p_last[0] = rx_tlast;
    p_v[1] = tx_tvalid && tx_tready; p_bytes[1] = $countones(tx_tkeep); p_last[1] = tx_tlast;
  endtask

  task automatic cyc();
    @(posedge core_clk);
    if (core_resetn) model_step();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    @(negedge core_clk);
    chk("rx_pkt",  64'(rx_pkt_cnt),  fmt(s_pkt[0], 32, 0));
    chk("rx_byte", 64'(rx_byte_cnt), fmt(s_byte[0], 32, 0));
    chk("tx_pkt",  64'(tx_pkt_cnt),  fmt(s_pkt[1], 32, 0));
    chk("tx_byte", 64'(tx_byte_cnt), fmt(s_byte[1], 32, 0));
    chk("rx_max",  64'(rx_max_len),  64'(m_max[0]));
    chk("tx_max",  64'(tx_max_len),  64'(m_max[1]));
    chk("ack",     64'(snapshot_ack), 64'(m_ack));
    chk("w_rx_pkt",  64'(w_rx_pkt),  fmt(m_pkt[0], 8, 0));
    chk("w_rx_byte", 64'(w_rx_byte), fmt(m_byte[0], 8, 0));
    chk("w_tx_pkt",  64'(w_tx_pkt),  fmt(m_pkt[1], 8, 0));
    chk("w_tx_byte", 64'(w_tx_byte), fmt(m_byte[1], 8, 0));
    chk("s_rx_pkt",  64'(s_rx_pkt),  fmt(m_pkt[0], 8, 1));
    chk("s_rx_byte", 64'(s_rx_byte), fmt(m_byte[0], 8, 1));
    chk("s_tx_pkt",  64'(s_tx_pkt),  fmt(m_pkt[1], 8, 1));
    chk("s_tx_byte", 64'(s_tx_byte), fmt(m_byte[1], 8, 1));
    chk("w_max", {w_rx_max, w_tx_max, s_rx_max, s_tx_max},
        {16'(m_max[0]), 16'(m_max[1]), 16'(m_max[0]), 16'(m_max[1])});
    chk("w_s_ack", {62'd0, w_ack, s_ack}, {62'd0, m_ack, m_ack});
  endtask

  task automatic send_rx(input logic [KW-1:0] keep, input logic last);
    rx_tvalid = 1; rx_tready = 1; rx_tkeep = keep; rx_tlast = last; cyc();
  endtask

  task automatic send_tx(input logic [KW-1:0] keep, input logic last);
    tx_tvalid = 1; tx_tready = 1; tx_tkeep = keep; tx_tlast = last; cyc();
  endtask

  task automatic idle(input int n);
    rx_tvalid = 0; tx_tvalid = 0; rx_tlast = 0; tx_tlast = 0;
    repeat (n) cyc();
  endtask

  task automatic snap();
    snapshot_req = 1; cyc(); snapshot_req = 0;
  endtask

  task automatic clear_all();
    clear_counters = 1; cyc(); clear_counters = 0;
  endtask

  initial begin
    rx_tkeep = '0; tx_tkeep = '0;
    rx_tvalid = 0; rx_tready = 0; rx_tlast = 0;
    tx_tvalid = 0; tx_tready = 0; tx_tlast = 0;
    clear_counters = 0; rx_pkt_clear = 0; rx_byte_clear = 0;
    tx_pkt_clear = 0; tx_byte_clear = 0; snapshot_req = 0;
    core_resetn = 0;
    model_reset();
    repeat (3) @(posedge core_clk);
    #1 core_resetn = 1;
    check_all();
    chk("reset_rx_pkt", 64'(rx_pkt_cnt), 64'd0);

    // Three-beat RX packet: 32 + 32 + 4 bytes
    send_rx('1, 0); send_rx('1, 0); send_rx(32'h0000000F, 1);
    idle(2); snap();
    check_all();
    chk("p1_rx_pkt",  64'(rx_pkt_cnt),  64'd1);
    chk("p1_rx_byte", 64'(rx_byte_cnt), 64'd68);
    chk("p1_rx_max",  64'(rx_max_len),  64'd68);
    chk("p1_tx_pkt",  64'(tx_pkt_cnt),  64'd0);

    // Valid without ready is never a beat
    rx_tvalid = 1; rx_tready = 0; rx_tkeep = '1; rx_tlast = 1;
    repeat (10) cyc();
    rx_tready = 1;
    idle(2); snap();
    check_all();
    chk("stall_rx_byte", 64'(rx_byte_cnt), 64'd68);
    send_rx(32'h0F0F0F0F, 1);
    idle(2); snap();
    check_all();
    chk("sparse_rx_byte", 64'(rx_byte_cnt), 64'd84);

    // 130 back-to-back single-beat packets on both directions
    clear_all();
    for (int i = 0; i < 130; i++) begin
      rx_tvalid = 1; rx_tready = 1; rx_tlast = 1; rx_tkeep = $urandom;
      tx_tvalid = 1; tx_tready = 1; tx_tlast = 1; tx_tkeep = $urandom;
      cyc();
    end
    idle(2); snap();
    check_all();
    chk("wrap_rx_pkt", 64'(w_rx_pkt), 64'h82);
    chk("sat_rx_pkt",  64'(s_rx_pkt), 64'hFF);
    chk("wrap_tx_pkt", 64'(w_tx_pkt), 64'h82);
    chk("sat_tx_pkt",  64'(s_tx_pkt), 64'hFF);
    chk("big_rx_pkt",  64'(rx_pkt_cnt), 64'd130);

    // Packet clear meets the last beat in stage 2
    clear_all();
    send_rx(32'h000000FF, 1);
    rx_tvalid = 0; rx_tlast = 0; rx_pkt_clear = 1; cyc(); rx_pkt_clear = 0;
    idle(1);
    check_all();
    chk("clr_rx_pkt",  64'(w_rx_pkt),  64'd0);
    chk("clr_rx_byte", 64'(w_rx_byte), 64'd8);

    // Atomic read-and-clear
    clear_all();
    for (int i = 0; i < 5; i++) send_tx(32'h00000003, 1);
    idle(2);
    snapshot_req = 1; clear_counters = 1; cyc(); snapshot_req = 0; clear_counters = 0;
    check_all();
    chk("rac_shadow", 64'(tx_pkt_cnt), 64'd5);
    chk("rac_live",   64'(w_tx_pkt),   64'd0);
    chk("rac_ack",    64'(snapshot_ack), 64'd1);
    cyc();
    check_all();

    // Reset in the middle of a packet, then a clean 64-byte packet
    send_rx('1, 0); send_rx('1, 0);
    rx_tvalid = 0;
    core_resetn = 0; model_reset();
    cyc();
    core_resetn = 1;
    send_rx('1, 0); send_rx('1, 1);
    idle(2); snap();
    check_all();
    chk("rst_rx_pkt",  64'(rx_pkt_cnt),  64'd1);
    chk("rst_rx_byte", 64'(rx_byte_cnt), 64'd64);
    chk("rst_rx_max",  64'(rx_max_len),  64'd64);

    // Randomised traffic with occasional clears and snapshots
    for (int i = 0; i < 400; i++) begin
      rx_tvalid = ($urandom_range(0, 3) != 0); rx_tready = ($urandom_range(0, 3) != 0);
      rx_tkeep  = $urandom;                    rx_tlast  = ($urandom_range(0, 3) == 0);
      tx_tvalid = ($urandom_range(0, 3) != 0); tx_tready = ($urandom_range(0, 3) != 0);
      tx_tkeep  = $urandom;                    tx_tlast  = ($urandom_range(0, 3) == 0);
      clear_counters = ($urandom_range(0, 59) == 0);
      rx_pkt_clear   = ($urandom_range(0, 19) == 0);
      rx_byte_clear  = ($urandom_range(0, 19) == 0);
      tx_pkt_clear   = ($urandom_range(0, 19) == 0);
      tx_byte_clear  = ($urandom_range(0, 19) == 0);
      snapshot_req   = ($urandom_range(0, 2) == 0);
      cyc();
      check_all();
    end
    clear_counters = 0; rx_pkt_clear = 0; rx_byte_clear = 0;
    tx_pkt_clear = 0; tx_byte_clear = 0; snapshot_req = 0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
